// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared state encoding, level width and default idle code for dac_sample_scheduler
package dac_sched_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t PRIME = 2'd1;
  localparam state_t RUN = 2'd2;
  localparam int DEF_DEPTH = 16;
  localparam int LVL_W = $clog2(DEF_DEPTH) + 1;
  localparam logic [7:0] DEF_IDLE_CODE = 8'h80;
endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: synchronous sample FIFO with push/pop, full/empty and occupancy level
module dac_sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: paces FIFO-buffered samples to dac_out at a programmable rate; DAC_UFLOW_CNT_EN adds uflow_cnt
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 32,
  parameter int PRIME_LEVEL = 4,
  parameter logic [DATA_W-1:0] IDLE_CODE = DEF_IDLE_CODE
) (
  input  logic                     main_clk,
  input  logic                     core_reset,
  input  logic                     enable,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     cfg_we,
  input  logic [DIV_W-1:0]         cfg_div,
  output logic [DATA_W-1:0]        dac_out,
  output logic                     sample_strobe,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef DAC_UFLOW_CNT_EN
  ,
  output logic [15:0]              uflow_cnt
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t state, nxt;
  logic [DIV_W-1:0] div_active, div_shadow, cnt;
  logic [DATA_W-1:0] head;
  logic full, empty, push, tick, pop, uflow;
  assign wr_ready = !full && !core_reset;
  assign push = wr_valid && wr_ready;
  assign tick = state == RUN && cnt == div_active;
  assign pop = tick && enable && !empty;
  assign uflow = tick && enable && empty;
  dac_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(main_clk), .rst(core_reset), .push(push), .pop(pop), .din(wr_data),
    .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb
    nxt = !enable ? IDLE :
          state == IDLE ? PRIME :
          state == PRIME ? (fifo_level >= LW'(PRIME_LEVEL) ? RUN : PRIME) :
          uflow ? PRIME : RUN;
  always_ff @(posedge main_clk) begin
    if (core_reset) begin
      state <= IDLE;
      div_active <= DIV_W'(DEFAULT_DIV);
      div_shadow <= DIV_W'(DEFAULT_DIV);
      cnt <= '0;
      dac_out <= IDLE_CODE;
      sample_strobe <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= nxt;
      sample_strobe <= pop;
      underflow <= uflow;
      div_shadow <= cfg_we ? cfg_div : div_shadow;
      // outside RUN a new divider takes effect at once; in RUN only at a period boundary
      div_active <= state != RUN ? (cfg_we ? cfg_div : div_shadow) : tick ? div_shadow : div_active;
      cnt <= (state != RUN || tick) ? '0 : cnt + DIV_W'(1);
      if (pop) dac_out <= head;
      else if (nxt == IDLE) dac_out <= IDLE_CODE;
    end
  end
`ifdef DAC_UFLOW_CNT_EN
  always_ff @(posedge main_clk) begin
    if (core_reset) uflow_cnt <= '0;
    else if (uflow && uflow_cnt != 16'hFFFF) uflow_cnt <= uflow_cnt + 16'd1;
  end
`endif
endmodule
